// File: rtl/dac_frame_scheduler_if.sv
// Requester-side bus of the DAC frame scheduler: per-channel enable mask,
// valid/data from the sample sources and the one-hot accept pulse back to them.
interface dac_frame_scheduler_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  logic [NCH-1:0]   chan_en;
  logic [NCH-1:0]   req_valid;
  logic [NCH*W-1:0] req_data;
  logic [NCH-1:0]   req_ready;

  // Sample sources (voices, tone generator) drive valid/data and see ready.
  modport master (
    output chan_en,
    output req_valid,
    output req_data,
    input  req_ready
  );

  // Scheduler side.
  modport slave (
    input  chan_en,
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/dac_frame_scheduler.sv
// DAC frame scheduler: once per DIV clocks, scans NCH requesters one per
// cycle, sums the accepted offset-binary samples around midscale, saturates
// the sum and commits it to the R2R DAC code register with a one-cycle strobe.
module dac_frame_scheduler #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int DIV = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  dac_frame_scheduler_if.slave req,
  output logic [W-1:0]         dac_code,
  output logic                 sample_strobe,
  output logic                 underrun,
  output logic [NCH-1:0]       missed_mask,
  output logic                 busy
);

  // Accumulator holds NCH signed deltas in [-2^(W-1), 2^(W-1)-1] plus the
  // midscale re-bias, so one guard bit beyond W+clog2(NCH) keeps it exact.
  localparam int AW = W + $clog2(NCH) + 1;
  localparam int PW = $clog2(NCH);
  localparam int DW = $clog2(DIV);

  localparam logic [W-1:0]          MID_CODE = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [AW-1:0] MID_A    = (AW)'(2 ** (W - 1));
  localparam logic signed [AW-1:0] MAX_A    = (AW)'((2 ** W) - 1);
  localparam logic [PW-1:0]        LAST_PTR = (PW)'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [PW-1:0]          ptr_reg, ptr_next;
  logic signed [AW-1:0]   acc_reg, acc_next;
  logic [NCH-1:0]         miss_reg, miss_next;
  logic [DW-1:0]          div_reg;
  logic [W-1:0]           dac_code_reg;
  logic                   underrun_reg;
  logic [NCH-1:0]         missed_mask_reg;

  logic                   tick;
  logic                   commit;
  logic [NCH-1:0]         ready_vec;
  logic [NCH-1:0]         miss_hit;
  logic signed [AW-1:0]   delta [NCH];
  logic signed [AW-1:0]   acc_add;
  logic signed [AW-1:0]   sat_sum;
  logic [W-1:0]           code_next;

  // Sample period divider; frozen whenever ena is low.
  assign tick = ena && (div_reg == (DW)'(DIV - 1));

  // Divider counter: 0..DIV-1, wraps on tick, holds while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
    end else if (ena) begin
      div_reg <= tick ? '0 : div_reg + (DW)'(1);
    end
  end

  // Per-channel decode: ready only for the channel under the scan pointer
  // when it is both enabled and valid; an enabled but idle channel is a miss.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic sel;
    assign sel          = (state_reg == SCAN) && (ptr_reg == (PW)'(gi)) && req.chan_en[gi];
    assign ready_vec[gi] = sel && req.req_valid[gi];
    assign miss_hit[gi]  = sel && !req.req_valid[gi];
    // Offset-binary sample re-centred to a signed delta around midscale.
    assign delta[gi]     = $signed((AW)'(req.req_data[gi*W +: W])) - MID_A;
  end

  assign req.req_ready = ready_vec;

  // Contribution of the channel accepted this cycle (at most one).
  always_comb begin
    acc_add = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ready_vec[i]) begin
        acc_add = delta[i];
      end
    end
  end

  // Next-state logic: scan NCH channels after a tick, then one commit cycle.
  // Ticks that land outside IDLE are ignored.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    acc_next   = acc_reg;
    miss_next  = miss_reg;
    commit     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (tick) begin
          state_next = SCAN;
          ptr_next   = '0;
          acc_next   = '0;
          miss_next  = '0;
        end
      end
      SCAN: begin
        acc_next  = acc_reg + acc_add;
        miss_next = miss_reg | miss_hit;
        if (ptr_reg == LAST_PTR) begin
          state_next = COMMIT;
          commit     = 1'b1;
        end else begin
          ptr_next = ptr_reg + (PW)'(1);
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Re-bias the frame sum to offset binary and clamp to the DAC range.
  always_comb begin
    sat_sum = acc_next + MID_A;
    if (sat_sum[AW-1]) begin
      code_next = '0;
    end else if (sat_sum > MAX_A) begin
      code_next = '1;
    end else begin
      code_next = sat_sum[W-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Frame datapath and output registers. The code is loaded on the edge that
  // ends the last scan cycle so it becomes visible together with the strobe
  // in the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg         <= '0;
      acc_reg         <= '0;
      miss_reg        <= '0;
      dac_code_reg    <= MID_CODE;
      underrun_reg    <= 1'b0;
      missed_mask_reg <= '0;
    end else begin
      ptr_reg  <= ptr_next;
      acc_reg  <= acc_next;
      miss_reg <= miss_next;
      if (commit) begin
        dac_code_reg    <= code_next;
        missed_mask_reg <= miss_next;
        underrun_reg    <= |miss_next;
      end
    end
  end

  assign dac_code      = dac_code_reg;
  assign sample_strobe = (state_reg == COMMIT);
  assign underrun      = underrun_reg;
  assign missed_mask   = missed_mask_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Scoreboard bench for dac_frame_scheduler (NCH=4, W=8, DIV=8): stimulus
// pushes expected ready pulses and commits; a negedge monitor pops/compares.
module tb_dac_frame_scheduler;
  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int DIV = 8;
  localparam int LIMIT = 3 * DIV;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic [W-1:0]   dac_code;
  logic           sample_strobe;
  logic           underrun;
  logic [NCH-1:0] missed_mask;
  logic           busy;

  always #5 clk = ~clk;

  dac_frame_scheduler_if #(.NCH(NCH), .W(W)) bus ();

  dac_frame_scheduler #(.NCH(NCH), .W(W), .DIV(DIV)) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .req           (bus),
    .dac_code      (dac_code),
    .sample_strobe (sample_strobe),
    .underrun      (underrun),
    .missed_mask   (missed_mask),
    .busy          (busy)
  );

  typedef struct {
    logic [W-1:0]   code;
    logic           under;
    logic [NCH-1:0] mask;
  } commit_t;

  int checks = 0;
  int errors = 0;
  logic [NCH-1:0] ready_q [$];
  commit_t        commit_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h want nothing", name, act);
  endtask

  // Monitor: every ready pulse and every strobe must match the next expectation.
  always @(negedge clk) begin : monitor
    logic [NCH-1:0] exp_r;
    commit_t        exp_c;
    if (bus.req_ready != '0) begin
      if (ready_q.size() == 0) begin
        fail_now("unexpected ready", 32'(bus.req_ready));
      end else begin
        exp_r = ready_q.pop_front();
        check("ready", 32'(bus.req_ready), 32'(exp_r));
        $display("ready %b expected %b", bus.req_ready, exp_r);
      end
    end
    if (sample_strobe) begin
      if (commit_q.size() == 0) begin
        fail_now("unexpected strobe", 32'(dac_code));
      end else begin
        exp_c = commit_q.pop_front();
        check("dac_code", 32'(dac_code), 32'(exp_c.code));
        check("underrun", 32'(underrun), 32'(exp_c.under));
        check("missed_mask", 32'(missed_mask), 32'(exp_c.mask));
        $display("commit code %h underrun %b mask %b", dac_code, underrun, missed_mask);
      end
    end
  end

  task automatic set_vec(input logic [3:0] en, input logic [3:0] valid, input logic [31:0] data);
    bus.chan_en   = en;
    bus.req_valid = valid;
    bus.req_data  = data;
  endtask

  task automatic expect_frame(input logic [7:0] code, input logic under, input logic [3:0] mask,
                              input logic [15:0] readies, input int nr);
    commit_t c;
    c.code  = code;
    c.under = under;
    c.mask  = mask;
    commit_q.push_back(c);
    for (int i = 0; i < nr; i++) ready_q.push_back(readies[i*4 +: 4]);
  endtask

  // Waits (bounded) for the next strobe; n = negedges elapsed.
  task automatic wait_strobe(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_strobe && n < 2 * LIMIT);
    if (!sample_strobe) fail_now({name, " strobe timeout"}, 32'(n));
  endtask

  task automatic wait_ready(input string name, input logic [3:0] want);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_ready != want && n < 2 * LIMIT);
    if (bus.req_ready != want) fail_now({name, " ready timeout"}, 32'(bus.req_ready));
  endtask

  task automatic run_vec(input string name, input logic [3:0] en, input logic [3:0] valid,
                         input logic [31:0] data, input logic [7:0] code, input logic under,
                         input logic [3:0] mask, input logic [15:0] readies, input int nr);
    int n;
    set_vec(en, valid, data);
    expect_frame(code, under, mask, readies, nr);
    wait_strobe(name, n);
  endtask

  initial begin : stimulus
    int n;
    int strobes;
    rst = 1'b1;
    ena = 1'b0;
    set_vec(4'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset dac_code", 32'(dac_code), 32'h80);
    check("reset ready", 32'(bus.req_ready), 32'h0);
    check("reset strobe", 32'(sample_strobe), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset underrun", 32'(underrun), 32'h0);
    check("reset mask", 32'(missed_mask), 32'h0);
    rst = 1'b0;

    // Full frame with latency check: strobe 4 cycles after the first ready.
    set_vec(4'hF, 4'hF, 32'h9090_9090);
    expect_frame(8'hC0, 1'b0, 4'b0000, 16'h8421, 4);
    ena = 1'b1;
    wait_ready("full frame", 4'b0001);
    check("busy in scan", 32'(busy), 32'h1);
    wait_strobe("full frame", n);
    check("commit latency", 32'(n), 32'd4);

    run_vec("sat high", 4'hF, 4'hF, 32'hFFFF_FFFF, 8'hFF, 1'b0, 4'b0000, 16'h8421, 4);
    run_vec("sat low",  4'hF, 4'hF, 32'h0000_0000, 8'h00, 1'b0, 4'b0000, 16'h8421, 4);
    run_vec("mix",      4'hF, 4'hF, 32'h8080_00FF, 8'h7F, 1'b0, 4'b0000, 16'h8421, 4);
    run_vec("all off",  4'h0, 4'hF, 32'h9090_9090, 8'h80, 1'b0, 4'b0000, 16'h0000, 0);
    run_vec("ch1 only", 4'b0010, 4'hF, 32'hFFFF_A0FF, 8'hA0, 1'b0, 4'b0000, 16'h0002, 1);
    run_vec("underrun", 4'hF, 4'b0010, 32'h5555_A055, 8'hA0, 1'b1, 4'b1101, 16'h0002, 1);

    // Reset right after ch1 is accepted: no further readies, no commit.
    set_vec(4'hF, 4'hF, 32'h9090_9090);
    ready_q.push_back(4'b0001);
    ready_q.push_back(4'b0010);
    wait_ready("mid reset", 4'b0010);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset dac_code", 32'(dac_code), 32'h80);
    check("mid reset underrun", 32'(underrun), 32'h0);
    check("mid reset mask", 32'(missed_mask), 32'h0);
    check("mid reset busy", 32'(busy), 32'h0);
    expect_frame(8'hC0, 1'b0, 4'b0000, 16'h8421, 4);
    rst = 1'b0;
    wait_strobe("after reset", n);
    check("first strobe after reset", 32'(n), 32'(DIV + NCH));

    // ena low for 3*DIV cycles: nothing happens, code holds.
    ena = 1'b0;
    strobes = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      if (sample_strobe) strobes++;
    end
    check("ena low strobes", 32'(strobes), 32'd0);
    check("ena low dac_code", 32'(dac_code), 32'hC0);

    // ena dropped during SCAN: that frame still commits exactly once.
    set_vec(4'hF, 4'hF, 32'h8080_8888);
    expect_frame(8'h90, 1'b0, 4'b0000, 16'h8421, 4);
    ena = 1'b1;
    wait_ready("ena drop", 4'b0001);
    ena = 1'b0;
    strobes = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      if (sample_strobe) strobes++;
    end
    check("ena drop strobes", 32'(strobes), 32'd1);
    check("ena drop dac_code", 32'(dac_code), 32'h90);

    check("ready queue drained", 32'(ready_q.size()), 32'd0);
    check("commit queue drained", 32'(commit_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dac_frame_scheduler.md
Name: dac_frame_scheduler

Overview:
- Shares the single 8-bit R2R DAC between NCH sample requesters (synth voices, test-tone source).
- A fixed-rate tick divider defines the DAC sample period. At each tick the block scans the requesters in order and accepts one sample from each over a valid/ready handshake.
- Accepted samples are summed around midscale with saturation. The result is committed to the DAC code register with a one-cycle strobe.
- Sits between the voice logic and the r2r bit inputs.

Parameters:
- NCH, 4, number of requesters (2..8).
- W, 8, sample and DAC code width (offset binary, midscale = 2^(W-1)).
- DIV, 256, clk cycles per DAC sample period. Requires DIV >= NCH+2.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- ena, input, 1, enables the tick divider. Low freezes the divider and holds dac_code.
- chan_en, input, NCH, per-requester enable mask.
- req_valid, input, NCH, requester has a sample ready.
- req_data, input, NCH*W, samples; channel i occupies bits [i*W +: W].
- req_ready, output, NCH, accept pulse (one-hot or zero).
- dac_code, output, W, registered code driving the DAC bits.
- sample_strobe, output, 1, one-cycle pulse when dac_code updates.
- underrun, output, 1, set at commit if any enabled channel was not valid when scanned.
- missed_mask, output, NCH, per-channel underrun flags for the last frame.
- busy, output, 1, high in SCAN and COMMIT.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): dac_code=2^(W-1) (0x80), sample_strobe=0, req_ready=0, underrun=0, missed_mask=0, busy=0, divider=0, state=IDLE, accumulator=0. Reset overrides everything, including an in-progress frame. The aborted frame produces no commit and no further ready pulses; the next cycle after rst deasserts is IDLE with divider=0.
- Divider: counts 0..DIV-1 while ena=1 and wraps to 0. tick is asserted when the count is DIV-1 and ena=1. While ena=0 the divider holds.
- State machine: IDLE, SCAN, COMMIT.
  - IDLE: on tick, go to SCAN with ptr=0 and acc=0.
  - SCAN: one channel per cycle, ptr = 0..NCH-1.
    - If chan_en[ptr] and req_valid[ptr]: req_ready[ptr]=1 (combinational, that cycle only) and acc += req_data[ptr] - 2^(W-1), signed.
    - If chan_en[ptr] and !req_valid[ptr]: no ready, acc unchanged, missed bit ptr set.
    - If !chan_en[ptr]: no ready, acc unchanged, missed bit not set.
    - After ptr=NCH-1, go to COMMIT.
  - COMMIT: registered update of dac_code = sat(acc + 2^(W-1)), clamped to [0, 2^W-1]. Also sample_strobe=1 for this one cycle, missed_mask = missed bits, underrun = |missed bits. Then go to IDLE.
- Accumulator: signed, W+clog2(NCH)+1 bits. It must not overflow for any input combination.
- Latency: tick at cycle T; scan cycles T+1..T+NCH; strobe and new dac_code visible at T+NCH+1.
- ena deasserted mid-frame: the frame completes and commits. The divider then stays frozen.
- A tick while busy is impossible because DIV >= NCH+2. An implementation must still ignore any tick outside IDLE.
- dac_code, underrun and missed_mask hold between commits.

Test Plan:
- Reset: assert rst 2 cycles -> dac_code=0x80, req_ready=0, sample_strobe=0, busy=0.
- Full frame, DIV=8, all chan_en=1, all valid with data 0x90 -> req_ready=0001,0010,0100,1000 on cycles T+1..T+4; strobe at T+5; dac_code=0xC0; underrun=0.
- Saturation: all four channels 0xFF -> dac_code=0xFF. All four channels 0x00 -> dac_code=0x00. A mix of 0xFF,0x00,0x80,0x80 -> 0x7F.
- Underrun and mask: only ch1 valid with 0xA0 and chan_en=1111 -> dac_code=0xA0, underrun=1, missed_mask=1101. With chan_en=0010 and the same stimulus -> underrun=0, missed_mask=0000, and ch0/2/3 never see ready even when valid.
- Reset mid-frame: rst asserted in the cycle after ch1 is accepted -> no ready pulses afterwards, no strobe, dac_code=0x80. The first strobe after release occurs DIV+NCH cycles later.
- ena low for 3*DIV cycles -> no strobe and dac_code unchanged. ena dropped during SCAN -> that frame still commits once.
